// File: rtl/router_pkg.sv
// Shared constants for the router datapath and its per-destination FIFOs.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package router_pkg;

    localparam int ROUTER_DATA_W       = 8;
    localparam int ROUTER_FIFO_DEPTH   = 16;
    localparam int ROUTER_FIFO_ADDR_W  = 4;

    // Payload-length field inside a header byte: header[LEN_MSB:LEN_LSB].
    localparam int LEN_MSB             = 7;
    localparam int LEN_LSB             = 2;

    // Each FIFO entry is {header_tag, data_byte}.
    localparam int ROUTER_FIFO_ENTRY_W = ROUTER_DATA_W + 1;

endpackage : router_pkg

// File: rtl/router_fifo.sv
// Per-destination output buffer: stores {header_tag, byte}, tracks packet length on read.
// Latency: data_out is registered, valid the cycle after an accepted read.
// Backpressure: writes while full and reads while empty are dropped; soft_reset flushes.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   soft_reset         synchronous flush (wins over read and write)
//   write_enb          write request; lfd_state marks data_in as a header byte
//   read_enb           read request from the destination
//   full, empty        combinational flags from the registered pointers
//   data_out           registered read byte, blanked to 0 between packets
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W,
    parameter int DEPTH  = ROUTER_FIFO_DEPTH,
    parameter int ADDR_W = ROUTER_FIFO_ADDR_W,
    parameter int LEN_W  = LEN_MSB - LEN_LSB + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] data_out
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0]  CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

    logic [DATA_W:0]   mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [LEN_W:0]    cnt;
    logic              wr_go;
    logic              rd_go;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    assign wr_go = write_enb && !full  && !soft_reset;
    assign rd_go = read_enb  && !empty && !soft_reset;

    // Storage. A flush leaves contents in place; they become unreachable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_go) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    // Pointers, remaining-length counter and registered read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            data_out <= '0;
        end else if (soft_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            data_out <= '0;
        end else begin
            if (wr_go) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_go) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= mem[rd_ptr[ADDR_W-1:0]][DATA_W-1:0];
                if (mem[rd_ptr[ADDR_W-1:0]][DATA_W]) begin
                    // Header: payload length plus one trailing parity byte.
                    cnt <= {1'b0, mem[rd_ptr[ADDR_W-1:0]][LEN_MSB:LEN_LSB]} + CNT_ONE;
                end else if (cnt != '0) begin
                    cnt <= cnt - CNT_ONE;
                end
            end else if (cnt == '0) begin
                // Between packets the output bus idles at zero.
                data_out <= '0;
            end
        end
    end

endmodule : router_fifo

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: directed packet scenarios plus random traffic.
// Latency: checks sample on the falling edge after each rising edge.
// Backpressure: reference model drops writes when full and reads when empty.
module tb_router_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       full;
    logic       empty;
    logic [7:0] data_out;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queue of {tag, byte}, remaining length, expected output.
    logic [8:0] mq[$];
    int         mcnt;
    logic [7:0] mdout;

    router_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .read_enb   (read_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .full       (full),
        .empty      (empty),
        .data_out   (data_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mcnt  = 0;
        mdout = 8'h00;
    endtask

    // One clock: drive inputs, advance the model from the pre-edge state,
    // clock the DUT, then compare flags and data on the falling edge.
    task automatic step(input string ph, input logic we, input logic re,
                        input logic lf, input logic [7:0] d, input logic sr);
        logic       rd_ok;
        logic       wr_ok;
        logic [8:0] e;
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lf;
        data_in    = d;
        soft_reset = sr;
        if (sr) begin
            model_clear();
        end else begin
            rd_ok = re && (mq.size() != 0);
            wr_ok = we && (mq.size() != 16);
            if (rd_ok) begin
                e     = mq.pop_front();
                mdout = e[7:0];
                if (e[8]) mcnt = int'(e[7:2]) + 1;
                else if (mcnt > 0) mcnt = mcnt - 1;
            end else if (mcnt == 0) begin
                mdout = 8'h00;
            end
            if (wr_ok) mq.push_back({lf, d});
        end
        @(posedge clock);
        @(negedge clock);
        chk({ph, "_full"},  32'(full),     32'(mq.size() == 16));
        chk({ph, "_empty"}, 32'(empty),    32'(mq.size() == 0));
        chk({ph, "_dout"},  32'(data_out), 32'(mdout));
    endtask

    task automatic idle(input string ph);
        step(ph, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] pkt [5];
        pkt[0] = 8'h0C; pkt[1] = 8'hA1; pkt[2] = 8'hA2; pkt[3] = 8'hA3; pkt[4] = 8'h5E;

        reset      = 1'b1;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        model_clear();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_empty", 32'(empty),    32'd1);
        chk("rst_full",  32'(full),     32'd0);
        chk("rst_dout",  32'(data_out), 32'd0);
        idle("idle");

        // Packet: header 0x0C (4 more bytes), payload, parity.
        for (int i = 0; i < 5; i++) step("pkt_wr", 1'b1, 1'b0, (i == 0), pkt[i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("pkt_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("pkt_byte", 32'(data_out), 32'(pkt[i]));
        end
        idle("pkt_end");
        chk("pkt_blank", 32'(data_out), 32'd0);

        // Fill to full, drop an overflow write, then read+write while full.
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        step("ovf", 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
        chk("ovf_full", 32'(full), 32'd1);
        step("rw_full", 1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
        chk("rw_full_dout", 32'(data_out), 32'h10);
        chk("rw_full_flag", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) begin
            step("drain", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            chk("drain_byte", 32'(data_out), 32'(8'h11 + i));
        end
        idle("drain_end");
        chk("drain_empty", 32'(empty), 32'd1);

        // Pointer wrap with concurrent traffic.
        for (int i = 0; i < 10; i++) step("wrap_wr", 1'b1, 1'b0, 1'b0, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 10; i++) step("wrap_rw", 1'b1, 1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 10; i++) step("wrap_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle("wrap_end");

        // Soft reset mid-packet with write and read requested in the same cycle.
        step("sr_wr", 1'b1, 1'b0, 1'b1, 8'h14, 1'b0);
        for (int i = 0; i < 4; i++) step("sr_wr", 1'b1, 1'b0, 1'b0, 8'(8'h21 + i), 1'b0);
        step("sr_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle("sr_hold");
        chk("sr_hold_dout", 32'(data_out), 32'h14);
        step("sr", 1'b1, 1'b1, 1'b0, 8'h99, 1'b1);
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_dout", 32'(data_out), 32'd0);
        idle("sr_after");
        chk("sr_after_empty", 32'(empty), 32'd1);
        step("sr_wr2", 1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
        step("sr_rd2", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("sr_rd2_dout", 32'(data_out), 32'h33);
        idle("sr_end");

        // Header with zero-length field: only the parity byte follows.
        step("len0_wr", 1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
        step("len0_wr", 1'b1, 1'b0, 1'b0, 8'h01, 1'b0);
        step("len0_hdr", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle("len0_gap");
        chk("len0_hold", 32'(data_out), 32'h01);
        step("len0_par", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("len0_par_dout", 32'(data_out), 32'h01);
        idle("len0_end");
        chk("len0_blank", 32'(data_out), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 49) == 0));
        end

        // Asynchronous reset in the middle of a write, between clock edges.
        for (int i = 0; i < 3; i++) step("ar_wr", 1'b1, 1'b0, (i == 0), 8'(8'h50 + i), 1'b0);
        step("ar_rd", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        write_enb = 1'b1;
        data_in   = 8'h77;
        #2 reset  = 1'b1;
        #1;
        chk("arst_empty", 32'(empty),    32'd1);
        chk("arst_full",  32'(full),     32'd0);
        chk("arst_dout",  32'(data_out), 32'd0);
        model_clear();
        @(negedge clock);
        write_enb = 1'b0;
        reset     = 1'b0;
        idle("arst_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_router_fifo
